shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//  Sequences one external 16-bit parallel/serial shift register for serial transfers.
//  Accepts a transfer request (word, direction, bit count) over a valid/ready handshake.
//  Parallel-loads the register, then issues one shift every CLKS_PER_BIT cycles for the requested bits.
//  Returns the final register contents over a second valid/ready handshake.
//  Sits between a host FSM and the shift register; it drives every control input of that register.
// PARAMETERS
//  REG_SIZE      16  width of the sequenced shift register and of the data words
//  CLKS_PER_BIT  4   clock cycles per shift (>=1); 1 = one shift per cycle
//  CNT_W         5   bit-count width, $clog2(REG_SIZE+1)
// PORTS
//  clock           in   1         system clock, all state changes on posedge
//  reset           in   1         asynchronous, active-high; forces IDLE
//  reqValid        in   1         host presents a transfer request
//  reqReady        out  1         sequencer can accept a request (IDLE only)
//  reqData         in   REG_SIZE  word to parallel-load
//  reqShiftRight   in   1         1 = shift toward bit 0, 0 = toward MSB
//  reqBits         in   CNT_W     bits to shift; 0 or >REG_SIZE means REG_SIZE
//  serialIn        in   1         bit fed into the register on each shift
//  abort           in   1         cancel the transfer in progress
//  srEnable        out  1         register enable
//  srLoadParallelly out 1         register parallel-load select
//  srShiftRight    out  1         register direction, held from the captured request
//  srSerialLoad    out  1         register serial input (= serialIn, combinational)
//  srParallelLoad  out  REG_SIZE  register parallel data (captured reqData)
//  srParallelOut   in   REG_SIZE  register parallelOutput
//  doneValid       out  1         result available
//  doneReady       in   1         host accepts the result
//  doneData        out  REG_SIZE  register contents after the last shift
//  busy            out  1         high in LOAD, SHIFT or DONE
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0, including reqReady; counters 0.
//   reqReady rises on the first clock edge after reset deasserts.
//  IDLE: reqReady=1. On reqValid&&reqReady: capture data, direction and normalised bit count.
//   Next state is LOAD; reqReady drops to 0 in the same edge.
//  LOAD (1 cycle): srEnable=1, srLoadParallelly=1. The register loads reqData on this edge.
//   Next state SHIFT; tick counter is set to CLKS_PER_BIT-1 and bitsLeft to the count.
//  SHIFT: srLoadParallelly=0. The tick counter decrements each cycle.
//   When tick==0: srEnable=1 for exactly that cycle, bitsLeft-1, tick reloads to CLKS_PER_BIT-1.
//   The first shift therefore occurs CLKS_PER_BIT cycles after the LOAD edge.
//   When the shift with bitsLeft==1 fires, next state is DONE.
//  DONE: doneValid=1; doneData latched from srParallelOut on the first DONE cycle.
//   Both are held stable until doneReady; on doneValid&&doneReady go to IDLE (reqReady=1 next cycle).
//  srEnable is 0 in IDLE and DONE, so the register holds its value there.
//  srShiftRight and srParallelLoad stay at the captured values until the next accept.
//  abort in LOAD or SHIFT: next state IDLE, no srEnable that cycle, no doneValid produced.
//   abort in IDLE or DONE is ignored.
//  abort and a tick==0 shift in the same cycle: abort wins, no shift.
//  reqValid asserted while not in IDLE: ignored. The host must hold it, and it is accepted on return to IDLE.
//  Total latency, accept to doneValid: 2 + bits*CLKS_PER_BIT cycles.
//  Reset asserted mid-transfer: immediate IDLE, srEnable=0 asynchronously, no doneValid.
// TESTING
//  1. Reset then accept 0xA5C3, right, 16 bits, CPB=1, serialIn=0.
//     -> doneValid at cycle 18 after accept; doneData=0x0000; exactly 16 srEnable pulses.
//  2. Accept 0x8001, left, 4 bits, CPB=4, serialIn=1 -> doneData=0x001F.
//     -> srEnable pulses spaced 4 cycles; doneValid 18 cycles after accept.
//  3. reqBits=0 and reqBits=20 -> both perform 16 shifts.
//  4. Abort on the 3rd shift cycle -> no shift that cycle; IDLE next; reqReady=1; doneValid never asserts.
//  5. doneReady held low 10 cycles while serialIn toggles -> doneData and register unchanged; srEnable=0.
//  6. Async reset mid-SHIFT, no clock edge -> all outputs 0 immediately; reqReady=1 one edge after release.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Host-side request/result handshakes of the shift sequencer.
// The master drives requests and accepts results; the slave is the sequencer.
interface shift_sequencer_if #(
  parameter int REG_SIZE = 16,
  parameter int CNT_W    = 5
);
  logic                reqValid;
  logic                reqReady;
  logic [REG_SIZE-1:0] reqData;
  logic                reqShiftRight;
  logic [CNT_W-1:0]    reqBits;
  logic                doneValid;
  logic                doneReady;
  logic [REG_SIZE-1:0] doneData;

  modport master (
    output reqValid, reqData, reqShiftRight, reqBits, doneReady,
    input  reqReady, doneValid, doneData
  );

  modport slave (
    input  reqValid, reqData, reqShiftRight, reqBits, doneReady,
    output reqReady, doneValid, doneData
  );
endinterface

// File: rtl/shift_sequencer.sv
// Drives an external parallel/serial shift register: parallel load, then one shift
// every CLKS_PER_BIT cycles for the requested bit count, then returns the register contents.
module shift_sequencer #(
  parameter int REG_SIZE     = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = $clog2(REG_SIZE + 1)
) (
  input  logic                clock,
  input  logic                reset,
  shift_sequencer_if.slave    host,
  input  logic                serialIn,
  input  logic                abort,
  output logic                srEnable,
  output logic                srLoadParallelly,
  output logic                srShiftRight,
  output logic                srSerialLoad,
  output logic [REG_SIZE-1:0] srParallelLoad,
  input  logic [REG_SIZE-1:0] srParallelOut,
  output logic                busy
);
  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT  = CNT_W'(REG_SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t              state;
  state_t              nextState;
  logic                armed;
  logic [TICK_W-1:0]   tick;
  logic [CNT_W-1:0]    bitsLeft;
  logic [CNT_W-1:0]    reqCount;
  logic                doneValidQ;
  logic [REG_SIZE-1:0] doneDataQ;
  logic                readyInt;
  logic                accept;
  logic                shiftNow;

  // armed keeps reqReady low until the first edge after reset releases
  assign readyInt       = (state == IDLE) && armed;
  assign accept         = host.reqValid && readyInt;
  assign host.reqReady  = readyInt;
  assign host.doneValid = doneValidQ;
  assign host.doneData  = doneDataQ;
  assign srSerialLoad   = serialIn;
  assign busy           = (state != IDLE);

  assign reqCount = ((host.reqBits == '0) || (host.reqBits > FULL_COUNT)) ? FULL_COUNT
                                                                           : host.reqBits;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState        = state;
    srEnable         = 1'b0;
    srLoadParallelly = 1'b0;
    shiftNow         = 1'b0;
    case (state)
      IDLE: begin
        if (accept) nextState = LOAD;
      end
      LOAD: begin
        if (abort) begin
          nextState = IDLE;
        end else begin
          srEnable         = 1'b1;
          srLoadParallelly = 1'b1;
          nextState        = SHIFT;
        end
      end
      SHIFT: begin
        // abort beats a shift due in the same cycle
        if (abort) begin
          nextState = IDLE;
        end else if (tick == '0) begin
          srEnable = 1'b1;
          shiftNow = 1'b1;
          if (bitsLeft == CNT_W'(1)) nextState = DONE;
        end
      end
      DONE: begin
        if (doneValidQ && host.doneReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed          <= 1'b0;
      tick           <= '0;
      bitsLeft       <= '0;
      doneValidQ     <= 1'b0;
      doneDataQ      <= '0;
      srShiftRight   <= 1'b0;
      srParallelLoad <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        srShiftRight   <= host.reqShiftRight;
        srParallelLoad <= host.reqData;
        bitsLeft       <= reqCount;
      end
      case (state)
        LOAD: tick <= TICK_RELOAD;
        SHIFT: begin
          if (!abort) begin
            if (shiftNow) begin
              tick     <= TICK_RELOAD;
              bitsLeft <= bitsLeft - CNT_W'(1);
            end else begin
              tick <= tick - TICK_W'(1);
            end
          end
        end
        DONE: begin
          // the register has settled after the last shift, so sample it once here
          if (!doneValidQ) begin
            doneValidQ <= 1'b1;
            doneDataQ  <= srParallelOut;
          end else if (host.doneReady) begin
            doneValidQ <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
